// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the LEGv8 execute stage: low N bits of a*b
// over N BUSY cycles, stalling IF/ID/EX until the one-cycle done_E pulse.
module mul_sequencer #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_E,
   input  logic         flush_E,
   input  logic [N-1:0] a_E,
   input  logic [N-1:0] b_E,
   output logic         stall_E,
   output logic         done_E,
   output logic [N-1:0] result_E
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_mcand;
   logic [N-1:0]  r_mplier;
   logic [N-1:0]  r_acc;
   logic [N-1:0]  r_result;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  w_sum;

   // Carry out of the single adder is dropped: only the low N bits are kept.
   assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (flush_E) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_E) begin
                  r_mcand  <= a_E;
                  r_mplier <= b_E;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_result <= w_sum;
                  r_state  <= S_DONE;
               end
            end
            // The start_E seen here belongs to the instruction now leaving EX.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_E  = !reset &&
                     (((r_state == S_IDLE) && start_E && !flush_E) || (r_state == S_BUSY));
   assign done_E   = (r_state == S_DONE);
   assign result_E = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed + randomized bench for mul_sequencer; expected products come from
// plain 64-bit multiplication and expected handshakes from cycle arithmetic.
module tb_mul_sequencer;
   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset, start_E, flush_E;
   logic [N-1:0] a_E, b_E;
   logic         stall_E, done_E;
   logic [N-1:0] result_E;

   int n_cmp = 0;
   int n_err = 0;
   logic [N-1:0] ref_result;

   mul_sequencer #(.N(N)) dut (
      .clk(clk), .reset(reset), .start_E(start_E), .flush_E(flush_E),
      .a_E(a_E), .b_E(b_E), .stall_E(stall_E), .done_E(done_E), .result_E(result_E)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [N-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Entered at a negedge; that cycle is cycle 0 (IDLE with start_E=1).
   task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] exp;
      exp = a * b;
      start_E = 1'b1; a_E = a; b_E = b;
      #1;
      chk({tag, ".stall_c0"}, N'(stall_E), N'(1));
      chk({tag, ".done_c0"},  N'(done_E),  N'(0));
      next_cycle();
      for (int c = 1; c <= N; c++) begin
         start_E = 1'b0; a_E = rnd64(); b_E = rnd64();
         #1;
         if (stall_E !== 1'b1 || done_E !== 1'b0) begin
            chk($sformatf("%s.stall_c%0d", tag, c), N'(stall_E), N'(1));
            chk($sformatf("%s.done_c%0d", tag, c),  N'(done_E),  N'(0));
         end else n_cmp++;
         next_cycle();
      end
      // start_E held high in DONE must be ignored (same instruction leaving EX)
      start_E = 1'b1; a_E = rnd64(); b_E = rnd64();
      #1;
      chk({tag, ".stall_done"}, N'(stall_E), N'(0));
      chk({tag, ".done"},       N'(done_E),  N'(1));
      chk({tag, ".result"},     result_E,    exp);
      ref_result = exp;
      next_cycle();
      start_E = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start_E = 1'b0; flush_E = 1'b0; a_E = '0; b_E = '0;
      ref_result = '0;
      @(negedge clk);
      next_cycle();
      chk("rst.stall",  N'(stall_E), N'(0));
      chk("rst.done",   N'(done_E),  N'(0));
      chk("rst.result", result_E,    N'(0));
      reset = 1'b0;
      next_cycle();
      #1 chk("idle.stall", N'(stall_E), N'(0));
      @(negedge clk);

      run_mul("m3x5", 64'd3, 64'd5);
      run_mul("zero", 64'h1234, 64'd0);
      run_mul("wrap1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      run_mul("wrap2", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

      // flush at cycle 10 of a 7x9
      start_E = 1'b1; a_E = 64'd7; b_E = 64'd9;
      next_cycle();
      start_E = 1'b0;
      for (int c = 1; c < 10; c++) next_cycle();
      flush_E = 1'b1;
      next_cycle();
      flush_E = 1'b0;
      #1;
      chk("flush.stall",  N'(stall_E), N'(0));
      chk("flush.done",   N'(done_E),  N'(0));
      chk("flush.result", result_E,    ref_result);
      @(negedge clk);
      run_mul("m6x7", 64'd6, 64'd7);

      // back-to-back: second start lands on the first IDLE cycle after DONE
      run_mul("b2b1", 64'd2, 64'd3);
      run_mul("b2b2", 64'd4, 64'd5);

      for (int k = 0; k < 6; k++)
         run_mul($sformatf("rnd%0d", k), rnd64(), rnd64());

      // reset at cycle 30 of a BUSY operation
      start_E = 1'b1; a_E = rnd64(); b_E = rnd64();
      next_cycle();
      start_E = 1'b0;
      for (int c = 1; c < 30; c++) next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      ref_result = '0;
      #1;
      chk("midrst.stall",  N'(stall_E), N'(0));
      chk("midrst.done",   N'(done_E),  N'(0));
      chk("midrst.result", result_E,    ref_result);
      @(negedge clk);
      begin
         int pulses;
         pulses = 0;
         for (int c = 0; c < N + 8; c++) begin
            #1 if (done_E === 1'b1) pulses++;
            next_cycle();
         end
         chk("midrst.no_done", N'(pulses), N'(0));
         chk("midrst.idle",    N'(stall_E), N'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
